// File: rtl/heart_status_controller.sv
// Per-player HP / heart-animation controller feeding the heart sprite renderer.
// Define HEART_SHAKE_EN to add the BREAKING-state horizontal jitter on shake_out.
module heart_status_controller #(
  parameter int unsigned MAX_HP        = 100,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned BLINK_FRAMES  = 4,
  parameter int unsigned BREAK_FRAMES  = 30
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        hit_valid_in,
  input  logic [7:0]  damage_in,
  input  logic        heal_valid_in,
  input  logic [7:0]  heal_in,
  input  logic        restart_in,
  output logic [7:0]  hp_out,
  output logic        divided_out,
  output logic        visible_out,
  output logic        dead_out,
  output logic [1:0]  shake_out
);

  localparam int unsigned HP_W  = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned EXT_W = 9;

  localparam logic [HP_W-1:0]  HP_FULL     = HP_W'(MAX_HP);
  localparam logic [EXT_W-1:0] INVULN_LAST = EXT_W'(INVULN_FRAMES);
  localparam logic [EXT_W-1:0] BLINK_LAST  = EXT_W'(BLINK_FRAMES);
  localparam logic [EXT_W-1:0] BREAK_LAST  = EXT_W'(BREAK_FRAMES);

  typedef enum logic [1:0] {
    ALIVE    = 2'd0,
    INVULN   = 2'd1,
    BREAKING = 2'd2,
    DEAD     = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] blink_cnt;
  logic             origin_q;

  logic             at_origin_c;
  logic             tick_c;
  logic [EXT_W-1:0] heal_sum_c;
  logic [HP_W-1:0]  heal_hp_c;
  logic [HP_W-1:0]  hit_hp_c;
  logic [EXT_W-1:0] frame_inc_c;
  logic [EXT_W-1:0] blink_inc_c;

  // Frame tick: rising edge of the (0,0) raster position, suppressed in reset
  assign at_origin_c = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign tick_c      = at_origin_c && !origin_q && !rst_in;

  // Saturating HP arithmetic; heal uses a 9-bit sum so it cannot wrap
  assign heal_sum_c  = {1'b0, hp_out} + {1'b0, heal_in};
  assign heal_hp_c   = (heal_sum_c > {1'b0, HP_FULL}) ? HP_FULL : heal_sum_c[HP_W-1:0];
  assign hit_hp_c    = (damage_in >= hp_out) ? '0 : HP_W'(hp_out - damage_in);

  assign frame_inc_c = {1'b0, frame_cnt} + EXT_W'(1);
  assign blink_inc_c = {1'b0, blink_cnt} + EXT_W'(1);

`ifdef HEART_SHAKE_EN
  logic [1:0] shake_phase;
  logic [1:0] shake_phase_inc_c;
  logic [1:0] shake_next_c;

  // Jitter pattern 0,2,0,1 indexed by phase
  assign shake_phase_inc_c = shake_phase + 2'd1;
  assign shake_next_c      = (shake_phase_inc_c == 2'd1) ? 2'd2 :
                             (shake_phase_inc_c == 2'd3) ? 2'd1 : 2'd0;
`else
  assign shake_out = 2'd0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= ALIVE;
      frame_cnt   <= '0;
      blink_cnt   <= '0;
      origin_q    <= 1'b0;
      hp_out      <= HP_FULL;
      divided_out <= 1'b0;
      visible_out <= 1'b1;
      dead_out    <= 1'b0;
`ifdef HEART_SHAKE_EN
      shake_phase <= 2'd0;
      shake_out   <= 2'd0;
`endif
    end else begin
      origin_q <= at_origin_c;
      if (restart_in) begin
        state       <= ALIVE;
        frame_cnt   <= '0;
        blink_cnt   <= '0;
        hp_out      <= HP_FULL;
        divided_out <= 1'b0;
        visible_out <= 1'b1;
        dead_out    <= 1'b0;
`ifdef HEART_SHAKE_EN
        shake_phase <= 2'd0;
        shake_out   <= 2'd0;
`endif
      end else begin
        case (state)
          ALIVE: begin
            // A hit wins over a same-cycle heal
            if (hit_valid_in) begin
              hp_out    <= hit_hp_c;
              frame_cnt <= '0;
              blink_cnt <= '0;
              if (hit_hp_c == '0) begin
                state       <= BREAKING;
                divided_out <= 1'b1;
                visible_out <= 1'b1;
`ifdef HEART_SHAKE_EN
                shake_phase <= 2'd0;
                shake_out   <= 2'd0;
`endif
              end else begin
                state       <= INVULN;
                visible_out <= 1'b0;
              end
            end else if (heal_valid_in) begin
              hp_out <= heal_hp_c;
            end
          end

          INVULN: begin
            if (heal_valid_in) begin
              hp_out <= heal_hp_c;
            end
            // Separate blink counter avoids a modulo on the frame count
            if (tick_c) begin
              if (frame_inc_c == INVULN_LAST) begin
                state       <= ALIVE;
                visible_out <= 1'b1;
                frame_cnt   <= '0;
                blink_cnt   <= '0;
              end else begin
                frame_cnt <= frame_inc_c[CNT_W-1:0];
                if (blink_inc_c == BLINK_LAST) begin
                  blink_cnt   <= '0;
                  visible_out <= ~visible_out;
                end else begin
                  blink_cnt <= blink_inc_c[CNT_W-1:0];
                end
              end
            end
          end

          BREAKING: begin
            if (tick_c) begin
              if (frame_inc_c == BREAK_LAST) begin
                state     <= DEAD;
                dead_out  <= 1'b1;
                frame_cnt <= '0;
`ifdef HEART_SHAKE_EN
                shake_phase <= 2'd0;
                shake_out   <= 2'd0;
`endif
              end else begin
                frame_cnt <= frame_inc_c[CNT_W-1:0];
`ifdef HEART_SHAKE_EN
                shake_phase <= shake_phase_inc_c;
                shake_out   <= shake_next_c;
`endif
              end
            end
          end

          DEAD: begin
            // Only restart leaves DEAD
            dead_out    <= 1'b1;
            divided_out <= 1'b1;
          end

          default: begin
            state <= ALIVE;
          end
        endcase
      end
    end
  end

endmodule
